pipe_add_sub: RTL and testbench

//  Parametrised, pipelined add/subtract unit that succeeds the fixed 32-bit ripple-of-CLA adder.

---
 rtl/pipe_add_sub.sv | 166 ++++++++++++++++
 tb/tb_pipe_add_sub.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_add_sub.sv
// Pipelined add/subtract unit with valid/ready handshakes on both sides.
// The operand is split into STAGES segments; each segment is added with
// BLK-bit carry-lookahead groups that ripple into one another, and the
// segment carry is registered before the next stage consumes it.
module pipe_add_sub #(
  parameter int WIDTH  = 32,
  parameter int BLK    = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int NGRP = SEG / BLK;

  if ((WIDTH % (STAGES * BLK)) != 0) begin : g_bad_params
    $error("pipe_add_sub: WIDTH must be a multiple of STAGES*BLK");
  end

  // One carry-lookahead group: every internal carry is formed directly from
  // generate/propagate terms and the group carry-in. Returns {cout, sum}.
  function automatic logic [BLK:0] cla_add(input logic [BLK-1:0] x,
                                           input logic [BLK-1:0] y,
                                           input logic           ci);
    logic [BLK-1:0] p;
    logic [BLK-1:0] g;
    logic [BLK:0]   c;
    logic           term;
    p    = x ^ y;
    g    = x & y;
    c    = '0;
    c[0] = ci;
    for (int i = 1; i <= BLK; i++) begin
      term = ci;
      for (int j = 0; j < i; j++) term = term & p[j];
      c[i] = term;
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int m = j + 1; m < i; m++) term = term & p[m];
        c[i] = c[i] | term;
      end
    end
    return {c[BLK], p ^ c[BLK-1:0]};
  endfunction

  genvar gi, gj;
  for (gi = 0; gi < STAGES; gi++) begin : g_stage
    logic [WIDTH-1:0] a_src;
    logic [WIDTH-1:0] b_src;
    logic [WIDTH-1:0] s_src;
    logic             c_src;
    logic             v_src;
    logic [SEG-1:0]   seg_sum;
    logic [NGRP:0]    seg_carry;
    logic [WIDTH-1:0] s_next;
    logic [WIDTH-1:0] s_reg;
    logic             c_reg;
    logic             v_reg;
    logic             adv;

    // Stage inputs: prepared operands at stage 0, previous stage registers after that.
    if (gi == 0) begin : g_src
      assign a_src = a;
      assign b_src = sub ? ~b : b;
      assign c_src = c_in ^ sub;
      assign s_src = '0;
      assign v_src = in_valid;
    end else begin : g_src
      assign a_src = g_stage[gi-1].g_pass.a_reg;
      assign b_src = g_stage[gi-1].g_pass.b_reg;
      assign c_src = g_stage[gi-1].c_reg;
      assign s_src = g_stage[gi-1].s_reg;
      assign v_src = g_stage[gi-1].v_reg;
    end

    // A stage may load when it is empty or its contents move on downstream.
    if (gi == STAGES - 1) begin : g_adv
      assign adv = !v_reg || out_ready;
    end else begin : g_adv
      assign adv = !v_reg || g_stage[gi+1].adv;
    end

    // Segment adder: CLA groups chained by a ripple carry.
    assign seg_carry[0] = c_src;
    for (gj = 0; gj < NGRP; gj++) begin : g_grp
      assign {seg_carry[gj+1], seg_sum[gj*BLK +: BLK]} =
        cla_add(a_src[gi*SEG + gj*BLK +: BLK], b_src[gi*SEG + gj*BLK +: BLK], seg_carry[gj]);
    end

    // Merge this segment's result bits into the partial sum passed down the pipe.
    always_comb begin
      s_next                = s_src;
      s_next[gi*SEG +: SEG] = seg_sum;
    end

    // Stage register: valid bit always follows the handshake, payload only on a real beat.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_reg <= 1'b0;
        s_reg <= '0;
        c_reg <= 1'b0;
      end else if (adv) begin
        v_reg <= v_src;
        if (v_src) begin
          s_reg <= s_next;
          c_reg <= seg_carry[NGRP];
        end
      end
    end

    // Operands still needed by later stages are carried along.
    if (gi < STAGES - 1) begin : g_pass
      logic [WIDTH-1:0] a_reg;
      logic [WIDTH-1:0] b_reg;

      // Pass-through operand register, loaded together with the stage payload.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_reg <= '0;
          b_reg <= '0;
        end else if (adv && v_src) begin
          a_reg <= a_src;
          b_reg <= b_src;
        end
      end
    end else begin : g_flags
      logic ovf_reg;
      logic ovf_next;

      // Carry into the MSB is recovered as a^b^sum at that bit.
      assign ovf_next = a_src[WIDTH-1] ^ b_src[WIDTH-1] ^ seg_sum[SEG-1] ^ seg_carry[NGRP];

      // Signed overflow flag registered alongside the final result.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_reg <= 1'b0;
        end else if (adv && v_src) begin
          ovf_reg <= ovf_next;
        end
      end
    end
  end

  assign in_ready  = g_stage[0].adv;
  assign out_valid = g_stage[STAGES-1].v_reg;
  assign sum       = g_stage[STAGES-1].s_reg;
  assign carry_out = g_stage[STAGES-1].c_reg;
  assign overflow  = g_stage[STAGES-1].g_flags.ovf_reg;
  assign zero      = (sum == '0);
  assign negative  = sum[WIDTH-1];

endmodule

// File: tb/tb_pipe_add_sub.sv
// Bench for pipe_add_sub: a 32-bit/2-stage and a 64-bit/4-stage instance are
// exercised in turn with directed beats, checked against an arithmetic model.
module tb_pipe_add_sub;

  typedef struct {
    logic [63:0] s;
    logic        co;
    logic        ov;
    logic        z;
    logic        n;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        phase = 1'b0;
  int          stg = 2;
  int          w = 32;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        c_in = 1'b0;
  logic        sub = 1'b0;

  logic        ir32, ov32, co32, of32, z32, n32;
  logic [31:0] s32;
  logic        ir64, ov64, co64, of64, z64, n64;
  logic [63:0] s64;

  logic        cur_in_ready, cur_out_valid, cur_co, cur_of, cur_z, cur_n;
  logic [63:0] cur_sum;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  res_t exp_q[$];
  logic [63:0] taken_s[$];
  int   taken_c[$];

  always #5 clk = ~clk;

  pipe_add_sub #(.WIDTH(32), .BLK(4), .STAGES(2)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid & ~phase), .in_ready(ir32),
    .a(a[31:0]), .b(b[31:0]), .c_in(c_in), .sub(sub),
    .out_valid(ov32), .out_ready(phase ? 1'b1 : out_ready), .sum(s32),
    .carry_out(co32), .overflow(of32), .zero(z32), .negative(n32));

  pipe_add_sub #(.WIDTH(64), .BLK(8), .STAGES(4)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid & phase), .in_ready(ir64),
    .a(a), .b(b), .c_in(c_in), .sub(sub),
    .out_valid(ov64), .out_ready(phase ? out_ready : 1'b1), .sum(s64),
    .carry_out(co64), .overflow(of64), .zero(z64), .negative(n64));

  assign cur_in_ready  = phase ? ir64 : ir32;
  assign cur_out_valid = phase ? ov64 : ov32;
  assign cur_sum       = phase ? s64 : {32'd0, s32};
  assign cur_co        = phase ? co64 : co32;
  assign cur_of        = phase ? of64 : of32;
  assign cur_z         = phase ? z64 : z32;
  assign cur_n         = phase ? n64 : n32;

  // Reference: plain wide arithmetic on the prepared operands.
  function automatic res_t model_calc(input logic [63:0] av, input logic [63:0] bv,
                                      input logic ci, input logic sb, input int wd);
    logic [64:0] full;
    logic [63:0] mask, am, bm;
    res_t r;
    mask = (wd == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    am   = av & mask;
    bm   = (sb ? ~bv : bv) & mask;
    full = {1'b0, am} + {1'b0, bm} + {64'd0, ci ^ sb};
    r.s  = full[63:0] & mask;
    r.co = full[wd];
    r.n  = r.s[wd-1];
    r.z  = (r.s == 64'd0);
    r.ov = (am[wd-1] == bm[wd-1]) && (r.s[wd-1] != am[wd-1]);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end else begin
      $display("ok   %s: %h", name, got);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: record accepted beats, compare every valid output cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && cur_in_ready)
        exp_q.push_back(model_calc(a, b, c_in, sub, w));
      if (cur_out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: got sum=%h with no beat outstanding", cur_sum);
        end else if (cur_sum !== exp_q[0].s || cur_co !== exp_q[0].co || cur_of !== exp_q[0].ov ||
                     cur_z !== exp_q[0].z || cur_n !== exp_q[0].n) begin
          errors++;
          $display("FAIL model_cmp: got sum=%h co=%b ov=%b z=%b n=%b want sum=%h co=%b ov=%b z=%b n=%b",
                   cur_sum, cur_co, cur_of, cur_z, cur_n,
                   exp_q[0].s, exp_q[0].co, exp_q[0].ov, exp_q[0].z, exp_q[0].n);
        end
        if (out_ready && exp_q.size() != 0) begin
          $display("xfer w=%0d sum=%h co=%b ov=%b z=%b n=%b", w, cur_sum, cur_co, cur_of, cur_z, cur_n);
          void'(exp_q.pop_front());
          taken_s.push_back(cur_sum);
          taken_c.push_back(cyc);
        end
      end
    end
  end

  task automatic send(input logic [63:0] av, input logic [63:0] bv, input logic ci,
                      input logic sb, output int stalls);
    int n = 0;
    a = av; b = bv; c_in = ci; sub = sb; in_valid = 1'b1;
    stalls = 0;
    @(negedge clk);
    while (!cur_in_ready && n < 50) begin
      stalls++;
      n++;
      @(negedge clk);
    end
    if (!cur_in_ready) chk("send_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_first(input logic [63:0] es, input logic eco, input logic eov,
                              input logic ez, input logic en);
    int lat = 1;
    while (!cur_out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'(stg));
    chk("sum", cur_sum, es);
    chk("carry_out", {63'd0, cur_co}, {63'd0, eco});
    chk("overflow", {63'd0, cur_of}, {63'd0, eov});
    chk("zero", {63'd0, cur_z}, {63'd0, ez});
    chk("negative", {63'd0, cur_n}, {63'd0, en});
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || cur_out_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) chk("drain_timeout", 64'd0, 64'd1);
  endtask

  task automatic reset_and_check();
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("rst_out_valid", {63'd0, cur_out_valid}, 64'd0);
    chk("rst_zero", {63'd0, cur_z}, 64'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sum", cur_sum, 64'd0);
    chk("rst_flags", {61'd0, cur_co, cur_of, cur_n}, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_in_ready", {63'd0, cur_in_ready}, 64'd1);
  endtask

  task automatic run_cases();
    logic [63:0] ones, maxpos, minneg;
    int st, base, acc, stale;
    ones   = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    maxpos = ones >> 1;
    minneg = ones ^ maxpos;
    out_ready = 1'b1;

    // Case 1: wrap to zero with carry out
    send(64'd1, ones, 1'b0, 1'b0, st);
    expect_first(64'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    drain();
    // Case 2: positive overflow
    send(maxpos, 64'd1, 1'b0, 1'b0, st);
    expect_first(minneg, 1'b0, 1'b1, 1'b0, 1'b1);
    drain();
    // Case 3: subtract with borrow, then with borrow-in
    send(64'd5, 64'd9, 1'b0, 1'b1, st);
    expect_first(ones - 64'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    drain();
    send(64'd9, 64'd5, 1'b1, 1'b1, st);
    expect_first(64'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    drain();

    // Case 4: back-to-back stream
    base = taken_s.size();
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      send(64'(i), 64'(i), 1'b0, 1'b0, st);
      acc += st;
    end
    drain();
    chk("b2b_stalls", 64'(acc), 64'd0);
    chk("b2b_count", 64'(taken_s.size() - base), 64'd8);
    for (int i = 0; i < 8 && base + i < taken_s.size(); i++) begin
      chk("b2b_sum", taken_s[base+i], 64'(2 * i));
      if (i > 0) chk("b2b_gap", 64'(taken_c[base+i] - taken_c[base+i-1]), 64'd1);
    end

    // Case 5: backpressure fills the pipe, then release
    base = taken_s.size();
    acc = 0;
    out_ready = 1'b0;
    a = 64'd100; b = 64'd7; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (cur_in_ready) acc++;
      @(posedge clk);
      #1;
      a = 64'(100 + acc);
    end
    chk("bp_accepted", 64'(acc), 64'(stg));
    chk("bp_in_ready", {63'd0, cur_in_ready}, 64'd0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();
    chk("bp_released", 64'(taken_s.size() - base), 64'(stg));
    if (taken_s.size() > base) chk("bp_first", taken_s[base], 64'd107);

    // Case 6: reset with two beats in flight
    send(64'd11, 64'd22, 1'b0, 1'b0, st);
    send(64'd33, 64'd44, 1'b0, 1'b0, st);
    reset_and_check();
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (cur_out_valid) stale++;
    end
    chk("no_stale", 64'(stale), 64'd0);
  endtask

  initial begin
    #1;
    chk("init_out_valid", {63'd0, cur_out_valid}, 64'd0);
    chk("init_zero", {63'd0, cur_z}, 64'd1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("init_in_ready", {63'd0, cur_in_ready}, 64'd1);
    run_cases();

    phase = 1'b1;
    stg = 4;
    w = 64;
    reset_and_check();
    run_cases();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
